// File: rtl/arm_pkg.sv
// Shared core-wide constants: datapath word width and the default fetch-queue depth.
package arm_pkg;

  localparam int WORD_W    = 32;
  localparam int IFQ_DEPTH = 4;

endpackage

// File: rtl/ifq_storage.sv
// Register array for the fetch/decode queue: one synchronous write port, asynchronous read.
// Contents are not reset; validity is tracked by the owner's occupancy count.
module ifq_storage
  import arm_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int DW    = 2 * WORD_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode decoupling queue of {pc, instruction}; flush discards all entries.
// Latency: 1 cycle push-to-head; 0 cycles from an empty queue when IFQ_BYPASS_EN is defined.
// Backpressure: full (freezes fetch) rejects push even with a same-cycle pop.
module if_id_queue
  import arm_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int WIDTH = WORD_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         in_pc,
  input  logic [WIDTH-1:0]         in_instruction,
  output logic                     full,
  input  logic                     pop,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_pc,
  output logic [WIDTH-1:0]         out_instruction,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]      rd_ptr, wr_ptr;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] rd_data;
  logic               q_valid, byp_hit, push_ok, pop_ok, wr_en, rd_en;

  always_comb begin
    q_valid = (cnt_q != '0);
    full    = (cnt_q == CW'(DEPTH));
`ifdef IFQ_BYPASS_EN
    byp_hit = ~q_valid & push & ~flush;
`else
    byp_hit = 1'b0;
`endif
    out_valid = q_valid | byp_hit;
    push_ok   = push & ~full;
    pop_ok    = pop & out_valid;
    // A bypassed pair that decode takes immediately never lands in storage.
    wr_en     = push_ok & ~flush & ~(byp_hit & pop_ok);
    rd_en     = pop_ok & q_valid & ~flush;

    out_pc          = '0;
    out_instruction = '0;
    if (byp_hit) begin
      out_pc          = in_pc;
      out_instruction = in_instruction;
    end else if (q_valid) begin
      out_pc          = rd_data[2*WIDTH-1:WIDTH];
      out_instruction = rd_data[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      cnt_q <= cnt_q + CW'(wr_en) - CW'(rd_en);
    end
  end

  assign count = cnt_q;

  ifq_storage #(
    .DEPTH (DEPTH),
    .DW    (2 * WIDTH),
    .AW    (AW)
  ) u_storage (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data ({in_pc, in_instruction}),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: driver predicts accepted pairs, negedge monitor checks head/flags.
module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk, rst, flush, push, pop;
  logic [WIDTH-1:0] in_pc, in_instruction, out_pc, out_instruction;
  logic             full, out_valid;
  logic [2:0]       count;

  if_id_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .push            (push),
    .in_pc           (in_pc),
    .in_instruction  (in_instruction),
    .full            (full),
    .pop             (pop),
    .out_valid       (out_valid),
    .out_pc          (out_pc),
    .out_instruction (out_instruction),
    .count           (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned chk_cnt  = 0;
  int unsigned pass_cnt = 0;
  bit          mon_en   = 1'b0;
  int          mdl_cnt  = 0;      // registered occupancy per the queue rules
  logic [63:0] exp_q[$];          // pairs expected at the head, oldest first
  logic [31:0] nxt_pc   = 32'd4;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Called just after a rising edge: drive one cycle and predict its effect.
  task automatic step(input bit p, input logic [31:0] pc, input bit po, input bit fl);
    logic [31:0] ins;
    bit byp, acc_push, acc_pop;
    int nxt;
    ins = $urandom;
    push = p; in_pc = pc; in_instruction = ins; pop = po; flush = fl;
    byp      = BYP && (mdl_cnt == 0) && p && !fl;
    acc_push = p && (mdl_cnt < DEPTH) && !fl;
    acc_pop  = po && ((mdl_cnt != 0) || byp) && !fl;
    if (fl) exp_q.delete();
    else if (acc_push) exp_q.push_back({pc, ins});
    nxt = fl ? 0 : mdl_cnt + int'(acc_push) - int'(acc_pop);
    @(posedge clk); #1;
    mdl_cnt = nxt;
  endtask

  task automatic push_seq(input bit po);
    step(1'b1, nxt_pc, po, 1'b0);
    nxt_pc += 4;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_valid;
      logic [63:0] head;
      exp_valid = (mdl_cnt != 0) || (BYP && (mdl_cnt == 0) && push && !flush);
      chk("count", 64'(count), 64'(mdl_cnt));
      chk("full", 64'(full), 64'(mdl_cnt == DEPTH));
      chk("out_valid", 64'(out_valid), 64'(exp_valid));
      if (!exp_valid) begin
        chk("idle_head", {out_pc, out_instruction}, 64'd0);
      end else if (out_valid && !flush) begin
        if (exp_q.size() == 0) begin
          chk("head_available", 64'd0, 64'd1);
        end else begin
          head = exp_q[0];
          chk("head_pc", 64'(out_pc), 64'(head[63:32]));
          chk("head_instruction", 64'(out_instruction), 64'(head[31:0]));
          if (pop) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b0; flush = 1'b0; push = 1'b1; pop = 1'b0;
    in_pc = 32'h44; in_instruction = 32'hdead_beef;
    // Reset held with push asserted
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_instruction", 64'(out_instruction), 64'd0);
    @(posedge clk); #1;
    push = 1'b0; rst = 1'b1; mon_en = 1'b1;
    @(posedge clk); #1;

    // Fill, overflow attempt, drain
    repeat (4) push_seq(1'b0);
    step(1'b1, 32'd20, 1'b0, 1'b0);
    step(1'b1, 32'd24, 1'b1, 1'b0);   // full: push rejected despite pop
    repeat (4) step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);    // pop on empty is ignored

    // Steady flow at count 2
    repeat (2) push_seq(1'b0);
    repeat (10) push_seq(1'b1);
    repeat (2) step(1'b0, 32'd0, 1'b1, 1'b0);

    // Flush at count 3 with push and pop
    repeat (3) push_seq(1'b0);
    step(1'b1, 32'h0bad_0000, 1'b1, 1'b1);
    push_seq(1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // Pointer wrap
    push_seq(1'b0);
    repeat (9) push_seq(1'b1);
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // Empty queue, push with pop
    step(1'b1, 32'h40, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // Random traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 60), nxt_pc, ($urandom_range(0, 99) < 50),
           ($urandom_range(0, 99) < 4));
      nxt_pc += 4;
    end

    // Asynchronous reset mid-operation
    repeat (3) push_seq(1'b0);
    mon_en = 1'b0;
    push = 1'b0; pop = 1'b0; flush = 1'b0;
    rst = 1'b0;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_pc", 64'(out_pc), 64'd0);
    exp_q.delete(); mdl_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b1; mon_en = 1'b1;
    push_seq(1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
